// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_seq_pkg;

    // Sequencer states, in the order a normal fetch walks through them.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT     = 3'd2,
        ST_PC_UPD   = 3'd3,
        ST_DISPATCH = 3'd4,
        ST_EXEC     = 3'd5,
        ST_ERR      = 3'd6
    } fetch_state_t;

    // Default number of WAIT cycles allowed for the IR acknowledge.
    localparam int FETCH_TIMEOUT_DEFAULT = 16;

    // Wide enough for the largest legal TIMEOUT (255).
    localparam int TMO_CNT_W = $clog2(255 + 1);

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts WAIT cycles spent waiting for the IR acknowledge and flags the
// last permitted cycle. The counter saturates at TIMEOUT-1 so it can never
// wrap back into the legal range while the FSM is still deciding.
module fetch_timeout_ctr
    import fetch_seq_pkg::*;
#(
    parameter int TIMEOUT = FETCH_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TMO_CNT_W-1:0] LAST_CNT = TMO_CNT_W'(TIMEOUT - 1);
    localparam logic [TMO_CNT_W-1:0] ONE      = TMO_CNT_W'(1);

    logic [TMO_CNT_W-1:0] r_count;
    logic                 w_at_last;

    assign w_at_last = (r_count == LAST_CNT);
    assign expired   = w_at_last;

    // Clear on request (or reset), otherwise count enabled WAIT cycles.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable && !w_at_last) begin
            r_count <= r_count + ONE;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-side control FSM: strobes write_ir / write_pc into the fetch register
// block, waits (bounded) for the IR acknowledge, then pulses ir_ready to
// execute and waits for retirement. All outputs are flops loaded from the
// decoded next state, so each one is a clean Moore output of the state.
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int TIMEOUT = FETCH_TIMEOUT_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt,
    input  logic             exec_done,
    input  logic             clr_err,
    input  logic             W_IR_valid,
    output logic             write_ir,
    output logic             write_pc,
    output logic             ir_ready,
    output logic             fetch_busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fetch_state_t     r_state;
    fetch_state_t     w_state_next;
    logic             w_tmo_clear;
    logic             w_tmo_enable;
    logic             w_tmo_expired;
    logic             w_cnt_inc;
    logic             w_fetch_ok;

    logic             r_write_ir;
    logic             r_write_pc;
    logic             r_ir_ready;
    logic             r_fetch_busy;
    logic             r_timeout_err;
    logic [CNT_W-1:0] r_fetch_count;

    // run/halt only matter in IDLE and when leaving EXEC.
    assign w_fetch_ok = run && !halt;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_tmo_clear),
        .enable  (w_tmo_enable),
        .expired (w_tmo_expired)
    );

    // Next-state logic; the acknowledge is checked before the timeout so a
    // late acknowledge on the last permitted cycle still wins.
    always_comb begin
        w_state_next = r_state;
        w_tmo_clear  = 1'b0;
        w_tmo_enable = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fetch_ok) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                w_tmo_clear  = 1'b1;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (W_IR_valid) begin
                    w_state_next = ST_PC_UPD;
                end else if (w_tmo_expired) begin
                    w_state_next = ST_ERR;
                end else begin
                    w_tmo_enable = 1'b1;
                end
            end
            ST_PC_UPD: begin
                w_cnt_inc    = 1'b1;
                w_state_next = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                w_state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (exec_done) begin
                    w_state_next = w_fetch_ok ? ST_REQ : ST_IDLE;
                end
            end
            ST_ERR: begin
                if (clr_err) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register and registered output decode of the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_write_ir    <= 1'b0;
            r_write_pc    <= 1'b0;
            r_ir_ready    <= 1'b0;
            r_fetch_busy  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_write_ir    <= (w_state_next == ST_REQ);
            r_write_pc    <= (w_state_next == ST_PC_UPD);
            r_ir_ready    <= (w_state_next == ST_DISPATCH);
            r_fetch_busy  <= (w_state_next == ST_REQ)    ||
                             (w_state_next == ST_WAIT)   ||
                             (w_state_next == ST_PC_UPD) ||
                             (w_state_next == ST_DISPATCH);
            r_timeout_err <= (w_state_next == ST_ERR);
        end
    end

    // Completed-fetch counter; bumps as PC_UPD is left and wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= '0;
        end else if (w_cnt_inc) begin
            r_fetch_count <= r_fetch_count + CNT_ONE;
        end
    end

    assign write_ir    = r_write_ir;
    assign write_pc    = r_write_pc;
    assign ir_ready    = r_ir_ready;
    assign fetch_busy  = r_fetch_busy;
    assign timeout_err = r_timeout_err;
    assign fetch_count = r_fetch_count;

endmodule
